// File: rtl/commit_buffer.sv
// In-order commit buffer: allocates entries, collects completions, retires up to COMMIT_W per cycle.
// Define COMMIT_BUFFER_FLUSH_EN to flush younger entries when a mispredicted branch retires.
module commit_buffer #(
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned COMMIT_W = 2,
    parameter int unsigned N_CMPL   = 3
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   push_en,
    input  logic                   push_kind,
    input  logic [7:0]             push_dest_logic,
    input  logic [1:0]             push_notify,
    output logic                   push_ready,
    output logic [7:0]             push_id,
    input  logic [N_CMPL-1:0]      cmpl_en,
    input  logic [N_CMPL*8-1:0]    cmpl_id,
    input  logic [N_CMPL*32-1:0]   cmpl_data,
    input  logic [N_CMPL-1:0]      cmpl_raise,
    input  logic [N_CMPL-1:0]      cmpl_taken,
    input  logic                   commit_ready,
    output logic [COMMIT_W-1:0]    commit_en,
    output logic [COMMIT_W-1:0]    commit_kind,
    output logic [COMMIT_W*8-1:0]  commit_dest_logic,
    output logic [COMMIT_W*2-1:0]  commit_notify,
    output logic [COMMIT_W*32-1:0] commit_data,
    output logic                   flush,
    output logic [15:0]            flush_pc,
    output logic [8:0]             count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    head_q, tail_q, occ_p, n_ret;
    logic [DEPTH-1:0] fin_q, kind_q, raise_q, taken_q;
    logic [7:0]       dest_q   [DEPTH];
    logic [1:0]       notify_q [DEPTH];
    logic [31:0]      data_q   [DEPTH];

    logic [AW-1:0]       head_idx, next_idx, tail_idx;
    logic [8:0]          occ;
    logic                can0, can1, flush_now, push_acc, head_mispredict;
    logic [COMMIT_W-1:0] slot_ok;
    logic [AW-1:0]       slot_idx [COMMIT_W];
    logic [N_CMPL-1:0]   cmpl_hit;
    logic [AW-1:0]       cmpl_slot [N_CMPL];
    logic [AW-1:0]       cmpl_off  [N_CMPL];

    assign head_idx = head_q[AW-1:0];
    assign next_idx = head_idx + AW'(1);
    assign tail_idx = tail_q[AW-1:0];
    assign occ_p    = tail_q - head_q;
    assign occ      = 9'(occ_p);
    assign count    = occ;
    assign push_id  = 8'(tail_idx);

`ifdef COMMIT_BUFFER_FLUSH_EN
    assign head_mispredict = kind_q[head_idx] & raise_q[head_idx];
`else
    assign head_mispredict = 1'b0;
`endif

    // Completions only land on entries inside the live window [head, tail).
    always_comb begin
        for (int p = 0; p < N_CMPL; p++) begin
            cmpl_slot[p] = cmpl_id[p*8 +: AW];
            cmpl_off[p]  = cmpl_slot[p] - head_idx;
            cmpl_hit[p]  = cmpl_en[p] && (32'(cmpl_id[p*8 +: 8]) < DEPTH)
                           && (9'(cmpl_off[p]) < occ);
        end
    end

    always_comb begin
        can0 = (occ != 9'd0) && fin_q[head_idx] && commit_ready;
        can1 = (COMMIT_W == 2) && can0 && (occ >= 9'd2) && fin_q[next_idx]
               && (notify_q[head_idx] == 2'b00) && (notify_q[next_idx] == 2'b00)
               && !head_mispredict;
        flush_now  = can0 && head_mispredict;
        push_ready = (occ != 9'(DEPTH)) && !flush_now;
        push_acc   = push_en && push_ready;
        n_ret      = PW'(can0) + PW'(can1);
        for (int s = 0; s < COMMIT_W; s++) begin
            slot_ok[s]  = (s == 0) ? can0 : can1;
            slot_idx[s] = head_idx + AW'(s);
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            head_q <= '0;
            tail_q <= '0;
            fin_q  <= '0;
        end else begin
            head_q <= head_q + n_ret;
            if (flush_now) begin
                tail_q <= head_q + PW'(1);
            end else if (push_acc) begin
                tail_q <= tail_q + PW'(1);
            end
            for (int p = 0; p < N_CMPL; p++) begin
                if (cmpl_hit[p]) fin_q[cmpl_slot[p]] <= 1'b1;
            end
            if (push_acc) fin_q[tail_idx] <= 1'b0;
        end
    end

    // Payload storage needs no reset; validity is tracked by fin_q and the pointers.
    always_ff @(posedge clk) begin
        for (int p = 0; p < N_CMPL; p++) begin
            if (cmpl_hit[p]) begin
                data_q[cmpl_slot[p]]  <= cmpl_data[p*32 +: 32];
                raise_q[cmpl_slot[p]] <= cmpl_raise[p];
                taken_q[cmpl_slot[p]] <= cmpl_taken[p];
            end
        end
        if (push_acc) begin
            kind_q[tail_idx]   <= push_kind;
            dest_q[tail_idx]   <= push_dest_logic;
            notify_q[tail_idx] <= push_notify;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            commit_en         <= '0;
            commit_kind       <= '0;
            commit_dest_logic <= '0;
            commit_notify     <= '0;
            commit_data       <= '0;
        end else begin
            for (int s = 0; s < COMMIT_W; s++) begin
                commit_en[s]             <= slot_ok[s];
                commit_kind[s]           <= slot_ok[s] & kind_q[slot_idx[s]];
                commit_dest_logic[s*8 +: 8] <= slot_ok[s] ? dest_q[slot_idx[s]] : 8'd0;
                commit_notify[s*2 +: 2]  <= slot_ok[s] ? notify_q[slot_idx[s]] : 2'd0;
                commit_data[s*32 +: 32]  <= slot_ok[s] ? data_q[slot_idx[s]] : 32'd0;
            end
        end
    end

`ifdef COMMIT_BUFFER_FLUSH_EN
    logic        flush_q;
    logic [15:0] flush_pc_q;
    always_ff @(posedge clk) begin
        if (!nreset) begin
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else begin
            flush_q    <= flush_now;
            flush_pc_q <= flush_now ? data_q[head_idx][15:0] : 16'd0;
        end
    end
    assign flush    = flush_q;
    assign flush_pc = flush_pc_q;
    logic unused_state;
    assign unused_state = ^taken_q;
`else
    assign flush    = 1'b0;
    assign flush_pc = 16'd0;
    logic unused_state;
    assign unused_state = ^{taken_q, raise_q};
`endif

endmodule

// File: tb/tb_commit_buffer.sv
// Directed self-checking bench for commit_buffer (DEPTH=4, COMMIT_W=2, N_CMPL=3).
// Flush expectations follow whether COMMIT_BUFFER_FLUSH_EN is defined for the build.
module tb_commit_buffer;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned COMMIT_W = 2;
    localparam int unsigned N_CMPL   = 3;

    logic                   clk = 1'b0;
    logic                   nreset;
    logic                   push_en;
    logic                   push_kind;
    logic [7:0]             push_dest_logic;
    logic [1:0]             push_notify;
    logic                   push_ready;
    logic [7:0]             push_id;
    logic [N_CMPL-1:0]      cmpl_en;
    logic [N_CMPL*8-1:0]    cmpl_id;
    logic [N_CMPL*32-1:0]   cmpl_data;
    logic [N_CMPL-1:0]      cmpl_raise;
    logic [N_CMPL-1:0]      cmpl_taken;
    logic                   commit_ready;
    logic [COMMIT_W-1:0]    commit_en;
    logic [COMMIT_W-1:0]    commit_kind;
    logic [COMMIT_W*8-1:0]  commit_dest_logic;
    logic [COMMIT_W*2-1:0]  commit_notify;
    logic [COMMIT_W*32-1:0] commit_data;
    logic                   flush;
    logic [15:0]            flush_pc;
    logic [8:0]             count;

    int n_asserts = 0;
    int n_fail    = 0;

    commit_buffer #(.DEPTH(DEPTH), .COMMIT_W(COMMIT_W), .N_CMPL(N_CMPL)) dut (
        .clk(clk), .nreset(nreset),
        .push_en(push_en), .push_kind(push_kind), .push_dest_logic(push_dest_logic),
        .push_notify(push_notify), .push_ready(push_ready), .push_id(push_id),
        .cmpl_en(cmpl_en), .cmpl_id(cmpl_id), .cmpl_data(cmpl_data),
        .cmpl_raise(cmpl_raise), .cmpl_taken(cmpl_taken),
        .commit_ready(commit_ready), .commit_en(commit_en), .commit_kind(commit_kind),
        .commit_dest_logic(commit_dest_logic), .commit_notify(commit_notify),
        .commit_data(commit_data), .flush(flush), .flush_pc(flush_pc), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cmpl();
        cmpl_en    = '0;
        cmpl_id    = '0;
        cmpl_data  = '0;
        cmpl_raise = '0;
        cmpl_taken = '0;
    endtask

    task automatic set_cmpl(input int p, input logic [7:0] id, input logic [31:0] d,
                            input logic r);
        cmpl_en[p]            = 1'b1;
        cmpl_id[p*8 +: 8]     = id;
        cmpl_data[p*32 +: 32] = d;
        cmpl_raise[p]         = r;
    endtask

    task automatic push(input logic k, input logic [7:0] dest, input logic [1:0] ntf);
        push_en         = 1'b1;
        push_kind       = k;
        push_dest_logic = dest;
        push_notify     = ntf;
        step();
        push_en = 1'b0;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        step();
        nreset = 1'b1;
    endtask

    initial begin
        push_en = 1'b0; push_kind = 1'b0; push_dest_logic = '0; push_notify = '0;
        clear_cmpl();
        commit_ready = 1'b1;
        nreset = 1'b0;
        step();
        step();
        nreset = 1'b1;

        // Reset state
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_commit_en", 64'(commit_en), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_push_ready", 64'(push_ready), 64'd1);
        chk("rst_push_id", 64'(push_id), 64'd0);
        chk("rst_commit_data", commit_data, 64'd0);

        // Out-of-order completion, dual retire
        for (int i = 0; i < 3; i++) begin
            chk("alloc_id", 64'(push_id), 64'(i));
            push(1'b0, 8'(10 + i), 2'b00);
        end
        chk("alloc_count", 64'(count), 64'd3);
        set_cmpl(0, 8'd2, 32'h22, 1'b0);
        step(); clear_cmpl();
        chk("ooo_wait2", 64'(commit_en), 64'd0);
        set_cmpl(1, 8'd1, 32'h11, 1'b0);
        step(); clear_cmpl();
        chk("ooo_wait1", 64'(commit_en), 64'd0);
        set_cmpl(0, 8'd0, 32'hAA, 1'b0);
        set_cmpl(2, 8'd0, 32'h10, 1'b0);
        step(); clear_cmpl();
        chk("ooo_decide_en", 64'(commit_en), 64'd0);
        chk("ooo_decide_count", 64'(count), 64'd3);
        step();
        chk("dual_en", 64'(commit_en), 64'd3);
        chk("dual_data", commit_data, 64'h0000_0011_0000_0010);
        chk("dual_dest", 64'(commit_dest_logic), 64'h0B0A);
        chk("dual_count", 64'(count), 64'd1);
        step();
        chk("tail_en", 64'(commit_en), 64'd1);
        chk("tail_data", commit_data, 64'h22);
        chk("tail_dest", 64'(commit_dest_logic), 64'h000C);
        chk("tail_count", 64'(count), 64'd0);
        step();
        chk("idle_en", 64'(commit_en), 64'd0);

        // Full buffer and wrap
        do_reset();
        for (int i = 0; i < 4; i++) push(1'b0, 8'(i), 2'b00);
        chk("full_count", 64'(count), 64'd4);
        chk("full_ready", 64'(push_ready), 64'd0);
        push_en = 1'b1; push_dest_logic = 8'hEE;
        step();
        step();
        push_en = 1'b0;
        chk("full_hold_count", 64'(count), 64'd4);
        chk("full_hold_id", 64'(push_id), 64'd0);
        set_cmpl(0, 8'd0, 32'h5, 1'b0);
        step(); clear_cmpl();
        chk("full_same_cycle_ready", 64'(push_ready), 64'd0);
        step();
        chk("full_commit_en", 64'(commit_en), 64'd1);
        chk("full_commit_count", 64'(count), 64'd3);
        chk("full_freed_ready", 64'(push_ready), 64'd1);
        chk("wrap_id", 64'(push_id), 64'd0);
        push(1'b0, 8'h77, 2'b00);
        chk("wrap_count", 64'(count), 64'd4);
        chk("wrap_next_id", 64'(push_id), 64'd1);

        // Notify on head suppresses slot 1
        do_reset();
        push(1'b0, 8'd1, 2'b01);
        push(1'b0, 8'd2, 2'b00);
        set_cmpl(0, 8'd0, 32'h100, 1'b0);
        set_cmpl(1, 8'd1, 32'h101, 1'b0);
        step(); clear_cmpl();
        chk("ntf_decide", 64'(commit_en), 64'd0);
        step();
        chk("ntf_first_en", 64'(commit_en), 64'd1);
        chk("ntf_first_notify", 64'(commit_notify), 64'h1);
        chk("ntf_first_data", commit_data, 64'h100);
        chk("ntf_first_count", 64'(count), 64'd1);
        step();
        chk("ntf_second_en", 64'(commit_en), 64'd1);
        chk("ntf_second_data", commit_data, 64'h101);
        chk("ntf_second_dest", 64'(commit_dest_logic), 64'h0002);
        chk("ntf_second_count", 64'(count), 64'd0);

        // Mispredicted branch at head
        do_reset();
        push(1'b1, 8'd0, 2'b00);
        push(1'b0, 8'd3, 2'b00);
        push(1'b0, 8'd4, 2'b00);
        set_cmpl(0, 8'd0, 32'h0040, 1'b1);
        set_cmpl(1, 8'd1, 32'h31, 1'b0);
        set_cmpl(2, 8'd2, 32'h32, 1'b0);
        step(); clear_cmpl();
`ifdef COMMIT_BUFFER_FLUSH_EN
        chk("flush_push_ready", 64'(push_ready), 64'd0);
        push(1'b0, 8'd9, 2'b00);
        chk("flush_commit_en", 64'(commit_en), 64'd1);
        chk("flush_kind", 64'(commit_kind), 64'd1);
        chk("flush_pulse", 64'(flush), 64'd1);
        chk("flush_pc", 64'(flush_pc), 64'h40);
        chk("flush_count", 64'(count), 64'd0);
        step();
        chk("flush_drop", 64'(flush), 64'd0);
        chk("flush_young_en", 64'(commit_en), 64'd0);
        chk("flush_after_count", 64'(count), 64'd0);
        chk("flush_after_id", 64'(push_id), 64'd1);
        step();
        chk("flush_young_en2", 64'(commit_en), 64'd0);
`else
        chk("br_push_ready", 64'(push_ready), 64'd1);
        push(1'b0, 8'd9, 2'b00);
        chk("br_commit_en", 64'(commit_en), 64'd3);
        chk("br_kind", 64'(commit_kind), 64'd1);
        chk("br_flush", 64'(flush), 64'd0);
        chk("br_flush_pc", 64'(flush_pc), 64'd0);
        chk("br_count", 64'(count), 64'd2);
        step();
        chk("br_next_en", 64'(commit_en), 64'd1);
        chk("br_next_data", commit_data, 64'h32);
        chk("br_next_count", 64'(count), 64'd1);
        chk("br_next_flush", 64'(flush), 64'd0);
`endif

        // Back-pressure, then mid-stream reset
        do_reset();
        push(1'b0, 8'd5, 2'b00);
        commit_ready = 1'b0;
        set_cmpl(0, 8'd0, 32'h55, 1'b0);
        step(); clear_cmpl();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_en", 64'(commit_en), 64'd0);
        end
        commit_ready = 1'b1;
        step();
        chk("bp_release_en", 64'(commit_en), 64'd1);
        chk("bp_release_data", commit_data, 64'h55);
        chk("bp_release_count", 64'(count), 64'd0);
        push(1'b0, 8'd6, 2'b00);
        push(1'b0, 8'd7, 2'b00);
        set_cmpl(0, 8'd1, 32'h61, 1'b0);
        set_cmpl(1, 8'd2, 32'h62, 1'b0);
        step(); clear_cmpl();
        do_reset();
        chk("mid_rst_en", 64'(commit_en), 64'd0);
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_id", 64'(push_id), 64'd0);
        chk("mid_rst_ready", 64'(push_ready), 64'd1);
        push(1'b0, 8'd8, 2'b00);
        step();
        step();
        chk("post_rst_unfin", 64'(commit_en), 64'd0);
        chk("post_rst_count", 64'(count), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
